hl_relu_ctrl: RTL and testbench

Sequencer for the hidden-layer activation stage of the MNIST MLP. After the hidden-layer MAC phase fills the 32-bit signed accumulator buffer, this block walks the buffer once. It streams each word through the combinational PE_relu, requantizes the result (shift right, saturate) to the output-layer activation width, and writes it to the activation buffer. It also counts positive neurons. Start/done handshake to the top-level layer FSM; throughput one neuron per cycle.

---
 rtl/hl_relu_ctrl.sv | 154 +++++++++++++++
 tb/tb_hl_relu_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hl_relu_ctrl.sv
// Hidden-layer activation sequencer: walks the accumulator buffer once, streams each
// word through the external ReLU PE, requantizes it and writes the activation buffer.
module hl_relu_ctrl #(
  parameter int DATA_W      = 32,
  parameter int NUM_NEURONS = 64,
  parameter int ADDR_W      = 6,
  parameter int OUT_W       = 8,
  parameter int SHIFT       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              hl_rd_en,
  output logic [ADDR_W-1:0] hl_rd_addr,
  input  logic [DATA_W-1:0] hl_rd_data,
  output logic [DATA_W-1:0] relu_in,
  input  logic [DATA_W-1:0] relu_out,
  output logic              act_wr_en,
  output logic [ADDR_W-1:0] act_wr_addr,
  output logic [OUT_W-1:0]  act_wr_data,
  output logic [ADDR_W:0]   pos_cnt
);

  // Handshake: start is accepted only in IDLE; busy covers RUN and DRAIN; done is a
  // single-cycle pulse in FIN, after which the block returns to IDLE for one cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [DATA_W-1:0] OUT_MAX   = {{(DATA_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drain_q, drain_d;
  logic              vld1_q, vld1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OUT_W-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W:0]   pos_cnt_q, pos_cnt_d;

  logic [DATA_W-1:0] shifted;
  logic [OUT_W-1:0]  quant;
  logic              pos_inc;

  assign relu_in = hl_rd_data;

  // relu_out is trusted to be non-negative, so a logical shift is sufficient.
  assign shifted = relu_out >> SHIFT;
  assign quant   = (shifted > OUT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  assign pos_inc = vld1_q && !hl_rd_data[DATA_W-1] && (|hl_rd_data);

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    drain_d   = drain_q;
    vld1_d    = rd_en_q;
    addr1_d   = rd_addr_q;
    wr_en_d   = vld1_q;
    wr_addr_d = vld1_q ? addr1_q : wr_addr_q;
    wr_data_d = vld1_q ? quant : wr_data_q;
    pos_cnt_d = pos_cnt_q + {{ADDR_W{1'b0}}, pos_inc};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          pos_cnt_d = '0;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Two cycles cover the read latency plus the output register stage.
        if (drain_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
          drain_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      vld1_q    <= 1'b0;
      addr1_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pos_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drain_q   <= drain_d;
      vld1_q    <= vld1_d;
      addr1_q   <= addr1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pos_cnt_q <= pos_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hl_rd_en    = rd_en_q;
  assign hl_rd_addr  = rd_addr_q;
  assign act_wr_en   = wr_en_q;
  assign act_wr_addr = wr_addr_q;
  assign act_wr_data = wr_data_q;
  assign pos_cnt     = pos_cnt_q;

endmodule

// File: tb/tb_hl_relu_ctrl.sv
// Directed bench for hl_relu_ctrl: three instances (4 neurons/shift 0, 4 neurons/shift 8,
// 1 neuron/shift 0) share clock and reset; each has its own buffer model and ReLU.
module tb_hl_relu_ctrl;

  logic clk;
  logic rst_n;
  logic [2:0]        start, busy, done, rd_en, wr_en;
  logic [2:0][1:0]   rd_addr, wr_addr;
  logic [2:0][31:0]  rd_data, relu_in, relu_out;
  logic [2:0][7:0]   wr_data;
  logic [2:0][2:0]   pos_cnt;
  logic [31:0]       mem [3][4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         rd_cnt [3];
  int         wr_cnt [3];
  int         done_cnt [3];
  int         rd_cyc [3][16];
  int         wr_cyc [3][16];
  int         done_cyc [3][4];
  logic [1:0] rd_addr_log [3][16];
  logic [1:0] wr_addr_log [3][16];
  logic [7:0] wr_data_log [3][16];
  logic [2:0] done_pos [3][4];
  logic       done_busy [3][4];
  logic [7:0] exp_q [$];

  hl_relu_ctrl #(.DATA_W(32), .NUM_NEURONS(4), .ADDR_W(2), .OUT_W(8), .SHIFT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .hl_rd_en(rd_en[0]), .hl_rd_addr(rd_addr[0]), .hl_rd_data(rd_data[0]),
    .relu_in(relu_in[0]), .relu_out(relu_out[0]), .act_wr_en(wr_en[0]),
    .act_wr_addr(wr_addr[0]), .act_wr_data(wr_data[0]), .pos_cnt(pos_cnt[0]));

  hl_relu_ctrl #(.DATA_W(32), .NUM_NEURONS(4), .ADDR_W(2), .OUT_W(8), .SHIFT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .hl_rd_en(rd_en[1]), .hl_rd_addr(rd_addr[1]), .hl_rd_data(rd_data[1]),
    .relu_in(relu_in[1]), .relu_out(relu_out[1]), .act_wr_en(wr_en[1]),
    .act_wr_addr(wr_addr[1]), .act_wr_data(wr_data[1]), .pos_cnt(pos_cnt[1]));

  hl_relu_ctrl #(.DATA_W(32), .NUM_NEURONS(1), .ADDR_W(2), .OUT_W(8), .SHIFT(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .hl_rd_en(rd_en[2]), .hl_rd_addr(rd_addr[2]), .hl_rd_data(rd_data[2]),
    .relu_in(relu_in[2]), .relu_out(relu_out[2]), .act_wr_en(wr_en[2]),
    .act_wr_addr(wr_addr[2]), .act_wr_data(wr_data[2]), .pos_cnt(pos_cnt[2]));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer with one-cycle read latency, and the ReLU PE
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i]) rd_data[i] <= mem[i][rd_addr[i]];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      relu_out[i] = (!relu_in[i][31] && (|relu_in[i])) ? relu_in[i] : 32'd0;
    end
  end

  // Observation log, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (rd_en[i]) begin
          if (rd_cnt[i] < 16) begin
            rd_addr_log[i][rd_cnt[i]] = rd_addr[i];
            rd_cyc[i][rd_cnt[i]] = cyc;
          end
          rd_cnt[i]++;
        end
        if (wr_en[i]) begin
          if (wr_cnt[i] < 16) begin
            wr_addr_log[i][wr_cnt[i]] = wr_addr[i];
            wr_data_log[i][wr_cnt[i]] = wr_data[i];
            wr_cyc[i][wr_cnt[i]] = cyc;
          end
          wr_cnt[i]++;
        end
        if (done[i]) begin
          if (done_cnt[i] < 4) begin
            done_cyc[i][done_cnt[i]] = cyc;
            done_pos[i][done_cnt[i]] = pos_cnt[i];
            done_busy[i][done_cnt[i]] = busy[i];
          end
          done_cnt[i]++;
        end
      end
    end
  end

  // Driver tasks
  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
      done_cnt[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic load(input int d, input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3);
    mem[d][0] = v0;
    mem[d][1] = v1;
    mem[d][2] = v2;
    mem[d][3] = v3;
  endtask

  task automatic run_pass(input int d, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1 start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (done[d]) ok = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    start = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], rd_en[i], wr_en[i], rd_addr[i], wr_addr[i], wr_data[i], pos_cnt[i]} !== 19'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %0h expected 0", i,
                 {busy[i], done[i], rd_en[i], wr_en[i], rd_addr[i], wr_addr[i], wr_data[i], pos_cnt[i]});
      end
    end
    rst_n = 1'b1;
    load(0, 32'd1, 32'd2, 32'd3, 32'd4);
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy[0], rd_en[0], wr_en[0]} !== 3'b111) begin
      errors++;
      $display("FAIL mid_run_active: got %b expected 111", {busy[0], rd_en[0], wr_en[0]});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy[0], rd_en[0], wr_en[0], done[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_drop: got %b expected 0000", {busy[0], rd_en[0], wr_en[0], done[0]});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy[0], rd_en[0], wr_en[0], rd_addr[0]} !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 00000", {busy[0], rd_en[0], wr_en[0], rd_addr[0]});
    end
    rst_n = 1'b1;
    clear_logs();
    run_pass(0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL post_reset_done: got timeout expected done pulse");
    end
    checks++;
    if (rd_cnt[0] != 4 || rd_addr_log[0][0] !== 2'd0 || wr_cnt[0] != 4) begin
      errors++;
      $display("FAIL post_reset_pass: got reads=%0d first_addr=%0d writes=%0d expected 4/0/4",
               rd_cnt[0], rd_addr_log[0][0], wr_cnt[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_data_log[0][k] !== 8'(k + 1)) begin
        errors++;
        $display("FAIL post_reset_data[%0d]: got %0d expected %0d", k, wr_data_log[0][k], k + 1);
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    load(0, 32'd10, -32'sd20, 32'd40, -32'sd60);
    exp_q.push_back(8'd10); exp_q.push_back(8'd0); exp_q.push_back(8'd40); exp_q.push_back(8'd0);
    run_pass(0, ok);
    checks++;
    if (!ok || rd_cnt[0] != 4 || wr_cnt[0] != 4 || done_cnt[0] != 1) begin
      errors++;
      $display("FAIL basic_counts: got ok=%0d reads=%0d writes=%0d dones=%0d expected 1/4/4/1",
               ok, rd_cnt[0], wr_cnt[0], done_cnt[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_data_log[0][k] !== exp_q[k] || wr_addr_log[0][k] !== 2'(k) || rd_addr_log[0][k] !== 2'(k)) begin
        errors++;
        $display("FAIL basic_write[%0d]: got data=%0d waddr=%0d raddr=%0d expected data=%0d addr=%0d",
                 k, wr_data_log[0][k], wr_addr_log[0][k], rd_addr_log[0][k], exp_q[k], k);
      end
      checks++;
      if (wr_cyc[0][k] != rd_cyc[0][k] + 2 || (k > 0 && rd_cyc[0][k] != rd_cyc[0][k-1] + 1)) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got rd=%0d wr=%0d expected wr=rd+2, reads contiguous",
                 k, rd_cyc[0][k], wr_cyc[0][k]);
      end
    end
    checks++;
    if (done_cyc[0][0] != rd_cyc[0][3] + 3) begin
      errors++;
      $display("FAIL basic_done_time: got %0d expected %0d", done_cyc[0][0], rd_cyc[0][3] + 3);
    end
    checks++;
    if (done_pos[0][0] !== 3'd2 || done_busy[0][0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_pos_at_done: got pos=%0d busy=%0d expected pos=2 busy=0",
               done_pos[0][0], done_busy[0][0]);
    end
    checks++;
    if (pos_cnt[0] !== 3'd2 || busy[0] !== 1'b0 || wr_data[0] !== 8'd0 || wr_addr[0] !== 2'd3) begin
      errors++;
      $display("FAIL basic_hold: got pos=%0d busy=%0d wdata=%0d waddr=%0d expected 2/0/0/3",
               pos_cnt[0], busy[0], wr_data[0], wr_addr[0]);
    end
  endtask

  task automatic test_requant();
    bit ok;
    logic [7:0] exp2 [4];
    clear_logs();
    load(1, 32'h0000_1234, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000);
    exp_q.push_back(8'h12); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    run_pass(1, ok);
    checks++;
    if (!ok || wr_cnt[1] != 4 || done_pos[1][0] !== 3'd3) begin
      errors++;
      $display("FAIL requant_pass: got ok=%0d writes=%0d pos=%0d expected 1/4/3", ok, wr_cnt[1], done_pos[1][0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_data_log[1][k] !== exp_q[k]) begin
        errors++;
        $display("FAIL requant_data[%0d]: got %0h expected %0h", k, wr_data_log[1][k], exp_q[k]);
      end
    end
    clear_logs();
    load(1, 32'h0000_0000, 32'h0000_0100, 32'h0000_01FF, 32'hFFFF_FF00);
    exp2 = '{8'h00, 8'h01, 8'h01, 8'h00};
    run_pass(1, ok);
    checks++;
    if (!ok || done_pos[1][0] !== 3'd2) begin
      errors++;
      $display("FAIL requant_zero_pos: got ok=%0d pos=%0d expected 1/2", ok, done_pos[1][0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_data_log[1][k] !== exp2[k]) begin
        errors++;
        $display("FAIL requant_small[%0d]: got %0h expected %0h", k, wr_data_log[1][k], exp2[k]);
      end
    end
  endtask

  task automatic test_boundary();
    bit ok;
    logic [7:0] exp4 [4];
    clear_logs();
    load(0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    exp4 = '{8'd0, 8'd1, 8'd0, 8'd0};
    run_pass(0, ok);
    checks++;
    if (!ok || done_pos[0][0] !== 3'd1 || wr_cnt[0] != 4) begin
      errors++;
      $display("FAIL boundary_pos: got ok=%0d pos=%0d writes=%0d expected 1/1/4", ok, done_pos[0][0], wr_cnt[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wr_data_log[0][k] !== exp4[k]) begin
        errors++;
        $display("FAIL boundary_data[%0d]: got %0d expected %0d", k, wr_data_log[0][k], exp4[k]);
      end
    end
    clear_logs();
    mem[2][0] = 32'h0000_0300;
    run_pass(2, ok);
    checks++;
    if (!ok || rd_cnt[2] != 1 || wr_cnt[2] != 1 || done_cnt[2] != 1) begin
      errors++;
      $display("FAIL single_counts: got ok=%0d reads=%0d writes=%0d dones=%0d expected 1/1/1/1",
               ok, rd_cnt[2], wr_cnt[2], done_cnt[2]);
    end
    checks++;
    if (wr_addr_log[2][0] !== 2'd0 || wr_data_log[2][0] !== 8'hFF || done_pos[2][0] !== 3'd1) begin
      errors++;
      $display("FAIL single_write: got addr=%0d data=%0h pos=%0d expected 0/ff/1",
               wr_addr_log[2][0], wr_data_log[2][0], done_pos[2][0]);
    end
    checks++;
    if (wr_cyc[2][0] != rd_cyc[2][0] + 2 || done_cyc[2][0] != rd_cyc[2][0] + 3) begin
      errors++;
      $display("FAIL single_timing: got rd=%0d wr=%0d done=%0d expected wr=rd+2 done=rd+3",
               rd_cyc[2][0], wr_cyc[2][0], done_cyc[2][0]);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] pat;
    pat = 8'b0110_1010;
    clear_logs();
    load(0, 32'd7, 32'd8, 32'd9, 32'd10);
    @(posedge clk); #1 start[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1 start[0] = pat[c];
    end
    start[0] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (rd_cnt[0] != 4 || wr_cnt[0] != 4 || done_cnt[0] != 1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: got reads=%0d writes=%0d dones=%0d busy=%0d expected 4/4/1/0",
               rd_cnt[0], wr_cnt[0], done_cnt[0], busy[0]);
    end
    checks++;
    if (wr_data_log[0][3] !== 8'd10 || done_pos[0][0] !== 3'd4) begin
      errors++;
      $display("FAIL start_ignored_data: got last=%0d pos=%0d expected 10/4", wr_data_log[0][3], done_pos[0][0]);
    end
  endtask

  task automatic test_back_to_back();
    int passes;
    int c;
    logic [2:0] exp_pos [3];
    passes = 0;
    c = 0;
    exp_pos = '{3'd2, 3'd2, 3'd0};
    clear_logs();
    load(0, 32'd10, -32'sd20, -32'sd30, 32'd40);
    @(posedge clk); #1 start[0] = 1'b1;
    while (passes < 3 && c < 120) begin
      @(negedge clk);
      c++;
      if (done[0]) begin
        passes++;
        if (passes == 1) load(0, 32'd50, -32'sd60, -32'sd70, 32'd80);
        else if (passes == 2) load(0, -32'sd1, -32'sd2, -32'sd3, -32'sd4);
        else start[0] = 1'b0;
      end
    end
    start[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (passes != 3 || done_cnt[0] != 3 || rd_cnt[0] != 12 || wr_cnt[0] != 12) begin
      errors++;
      $display("FAIL b2b_counts: got passes=%0d dones=%0d reads=%0d writes=%0d expected 3/3/12/12",
               passes, done_cnt[0], rd_cnt[0], wr_cnt[0]);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (done_pos[0][p] !== exp_pos[p]) begin
        errors++;
        $display("FAIL b2b_pos[%0d]: got %0d expected %0d", p, done_pos[0][p], exp_pos[p]);
      end
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rd_cyc[0][4*(p+1)] != done_cyc[0][p] + 2) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: got next read at %0d expected %0d", p, rd_cyc[0][4*(p+1)], done_cyc[0][p] + 2);
      end
    end
    checks++;
    if (wr_data_log[0][4] !== 8'd50 || wr_data_log[0][7] !== 8'd80 || wr_data_log[0][8] !== 8'd0) begin
      errors++;
      $display("FAIL b2b_data: got %0d/%0d/%0d expected 50/80/0",
               wr_data_log[0][4], wr_data_log[0][7], wr_data_log[0][8]);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_requant();
    test_boundary();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
